// File: rtl/demux_reg.sv
// ============================================================================
// Module   : demux_reg
// Brief    : Registered N-way demultiplexer. One valid/ready input stream is
//            steered by in_sel into one of 2^SWITCH_BITS single-entry holding
//            registers, each with its own valid/ready handshake downstream.
//            Optional broadcast mode: define DEMUX_REG_BCAST_EN to add the
//            in_bcast port, which loads every lane with one accepted word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_reg #(
  parameter int SWITCH_BITS = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SWITCH_BITS-1:0]                  in_sel,
  input  logic [DATA_WIDTH-1:0]                   in_data,
`ifdef DEMUX_REG_BCAST_EN
  input  logic                                    in_bcast,
`endif
  output logic [(1<<SWITCH_BITS)-1:0]             out_valid,
  input  logic [(1<<SWITCH_BITS)-1:0]             out_ready,
  output logic [(1<<SWITCH_BITS)*DATA_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]                    xfer_cnt
);

  // Lane count follows from the select width; it is not a free parameter.
  localparam int LANES = 1 << SWITCH_BITS;

  logic [LANES-1:0]                 valid_q;
  logic [LANES-1:0]                 valid_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] data_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] data_d;
  logic [CNT_WIDTH-1:0]             cnt_q;
  logic [CNT_WIDTH-1:0]             cnt_d;

  logic [LANES-1:0] w_lane_free;
  logic [LANES-1:0] w_load;
  logic             w_bcast;
  logic             w_ready_sel;
  logic             w_accept;

`ifdef DEMUX_REG_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A lane can take a word when it is empty or is being drained this cycle.
  assign w_lane_free = ~valid_q | out_ready;

  // Unicast needs only the selected lane free; broadcast needs all of them.
  always_comb begin
    w_ready_sel = w_lane_free[in_sel];
    if (w_bcast) begin
      w_ready_sel = &w_lane_free;
    end
  end

  // rst is active-low, so it gates in_ready off for the whole reset period.
  assign in_ready = rst & w_ready_sel;
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      // Load wins over drain, so a drain+load keeps the lane full with new data.
      always_comb begin
        w_load[i]  = w_accept & (w_bcast | (in_sel == SWITCH_BITS'(i)));
        valid_d[i] = w_load[i] | (valid_q[i] & ~out_ready[i]);
        data_d[i]  = w_load[i] ? in_data : data_q[i];
      end

      // Per-lane holding register; data is kept (not cleared) after a drain.
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
        end else begin
          valid_q[i] <= valid_d[i];
          data_q[i]  <= data_d[i];
        end
      end
    end
  endgenerate

  // One count per accepted input word, regardless of how many lanes it fills.
  assign cnt_d = cnt_q + CNT_WIDTH'(w_accept);

  // Accepted-transfer counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_reg.sv
// ============================================================================
// Module   : tb_demux_reg
// Brief    : Self-checking bench for demux_reg (4 lanes, 8-bit data, 4-bit
//            counter). Handshake/counter expectations come from a vector
//            table and hand-written sequences; delivered data is checked by a
//            per-lane scoreboard queue. Broadcast checks build only when
//            DEMUX_REG_BCAST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_reg;

  localparam int SB = 2;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int NL = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SB-1:0]     in_sel;
  logic [DW-1:0]     in_data;
  logic              in_bcast;
  logic [NL-1:0]     out_valid;
  logic [NL-1:0]     out_ready;
  logic [NL*DW-1:0]  out_data;
  logic [CW-1:0]     xfer_cnt;

  int total;
  int bad;

  logic [DW-1:0] sb [NL][$];
  logic [NL-1:0] prev_ov;

  demux_reg #(
    .SWITCH_BITS (SB),
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
`ifdef DEMUX_REG_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus. Expected in_ready is checked before the edge,
  // expected out_valid / xfer_cnt after it. Held lane data is compared with
  // the scoreboard front; drains pop, accepts push.
  task automatic drive(input string nm, input logic r, input logic v,
                       input logic [SB-1:0] sel, input logic [DW-1:0] d,
                       input logic [NL-1:0] ordy, input logic bc,
                       input logic er, input logic [NL-1:0] eov,
                       input logic [CW-1:0] ecnt);
    rst       = r;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    in_bcast  = bc;
    #4;
    chk({nm, " in_ready"}, 32'(in_ready), 32'(er));
    if (r) begin
      for (int i = 0; i < NL; i++) begin
        if (prev_ov[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("%s lane%0d scoreboard empty", nm, i), 32'(1), 32'(0));
          end else begin
            chk($sformatf("%s lane%0d data", nm, i),
                32'(out_data[i*DW +: DW]), 32'(sb[i][0]));
            if (ordy[i]) void'(sb[i].pop_front());
          end
        end
      end
      if (v && er) begin
        for (int i = 0; i < NL; i++) begin
          if (bc || (int'(sel) == i)) sb[i].push_back(d);
        end
      end
    end
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(out_valid), 32'(eov));
    chk({nm, " xfer_cnt"}, 32'(xfer_cnt), 32'(ecnt));
    if (!r) begin
      for (int i = 0; i < NL; i++) sb[i].delete();
      chk({nm, " out_data cleared"}, out_data, 32'h0);
    end
    prev_ov = eov;
  endtask

  typedef struct {
    logic          r;
    logic          v;
    logic [SB-1:0] sel;
    logic [DW-1:0] d;
    logic [NL-1:0] ordy;
    logic          er;
    logic [NL-1:0] eov;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    total     = 0;
    bad       = 0;
    prev_ov   = '0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    in_bcast  = 1'b0;
    out_ready = '0;

    //            r     v     sel   data   ordy     er    eov      cnt
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 8'h99, 4'b0000, 1'b0, 4'b0000, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'h99, 4'b0000, 1'b0, 4'b0000, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 4'd0};
    tbl[3]  = '{1'b1, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 4'd1};
    tbl[4]  = '{1'b1, 1'b1, 2'd2, 8'h3C, 4'b0000, 1'b0, 4'b0100, 4'd1};
    tbl[5]  = '{1'b1, 1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0101, 4'd2};
    tbl[6]  = '{1'b1, 1'b1, 2'd2, 8'h3C, 4'b0100, 1'b1, 4'b0101, 4'd3};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 8'h00, 4'b1111, 1'b1, 4'b0000, 4'd3};
    tbl[8]  = '{1'b1, 1'b1, 2'd1, 8'h55, 4'b0010, 1'b1, 4'b0010, 4'd4};
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 8'h66, 4'b0000, 1'b1, 4'b1010, 4'd5};
    tbl[10] = '{1'b1, 1'b1, 2'd1, 8'h77, 4'b1000, 1'b0, 4'b0010, 4'd5};
    tbl[11] = '{1'b1, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0000, 4'd5};

    for (int k = 0; k < 12; k++) begin
      drive($sformatf("vec%0d", k), tbl[k].r, tbl[k].v, tbl[k].sel, tbl[k].d,
            tbl[k].ordy, 1'b0, tbl[k].er, tbl[k].eov, tbl[k].ecnt);
      if (k == 7) begin
        // Drained lanes keep their last word on out_data.
        chk("hold after drain lane0", 32'(out_data[0*DW +: DW]), 32'h11);
        chk("hold after drain lane2", 32'(out_data[2*DW +: DW]), 32'h3C);
      end
    end

    // Counter wrap: 17 accepts on a 4-bit counter end at 1.
    drive("wrap rst", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'd0);
    for (int k = 0; k < 17; k++) begin
      logic [SB-1:0] s;
      logic [NL-1:0] oh;
      s  = SB'(k % NL);
      oh = NL'(1) << s;
      drive($sformatf("wrap%0d", k), 1'b1, 1'b1, s, 8'(8'h20 + k), 4'b1111,
            1'b0, 1'b1, oh, CW'(k + 1));
    end
    chk("wrap final count", 32'(xfer_cnt), 32'd1);
    drive("wrap drain", 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'd1);

    // Reset in the middle of traffic discards held words.
    drive("mid load", 1'b1, 1'b1, 2'd0, 8'h09, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'd2);
    drive("mid rst",  1'b0, 1'b1, 2'd0, 8'h0A, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'd0);
    drive("mid rel",  1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd0);

`ifdef DEMUX_REG_BCAST_EN
    // Broadcast blocked by one stalled lane, then released.
    drive("bc load1", 1'b1, 1'b1, 2'd1, 8'h42, 4'b0000, 1'b0, 1'b1, 4'b0010, 4'd1);
    drive("bc stall", 1'b1, 1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 1'b0, 4'b0010, 4'd1);
    drive("bc go",    1'b1, 1'b1, 2'd0, 8'h77, 4'b0010, 1'b1, 1'b1, 4'b1111, 4'd2);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("bc lane%0d data", i), 32'(out_data[i*DW +: DW]), 32'h77);
    end
    drive("bc drain", 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'd2);
`endif

    for (int i = 0; i < NL; i++) begin
      chk($sformatf("scoreboard lane%0d leftover", i), 32'(sb[i].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
